// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-side drain engine for a FIFO with a registered RAM read port (rdata
//   is valid one rclk after an accepted read). Pops WIDTH-bit entries and packs
//   PACK of them, LSB lane first, into one wide word. The word is offered on a
//   valid/ready output. A flush pulse emits a partially filled word.
//
// Ports
//   rclk       read clock, the only clock
//   rrst       asynchronous reset, active high
//   rempty     FIFO empty flag
//   rinc       FIFO read request (combinational)
//   rdata      FIFO read data, valid the cycle after an accepted rinc
//   flush      one-cycle pulse: emit the partial word accumulated so far
//   out_data   packed word, lane i = out_data[i*WIDTH +: WIDTH]
//   out_cnt    number of valid lanes in out_data (1..PACK)
//   out_valid  out_data/out_cnt valid
//   out_ready  consumer accepts when out_valid && out_ready
//   busy       lanes held, a read in flight, or a flush pending
module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4,
  parameter int CW    = $clog2(PACK + 1)
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  output logic                  rinc,
  input  logic [WIDTH-1:0]      rdata,
  input  logic                  flush,
  output logic [WIDTH*PACK-1:0] out_data,
  output logic [CW-1:0]         out_cnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam logic [CW:0]   PACK_W = (CW + 1)'(PACK);
  localparam logic [CW-1:0] PACK_C = CW'(PACK);

  logic [WIDTH*PACK-1:0] acc;
  logic [CW-1:0]         cnt;
  logic                  pend;
  logic                  fl;

  logic out_free;
  logic full_move;
  logic flush_move;
  logic flush_drop;

  always_comb begin
    out_free   = !out_valid || out_ready;
    full_move  = (cnt == PACK_C) && out_free;
    // A full accumulator always leaves as a full word; a pending flush then
    // finds cnt == 0 and retires without producing output.
    flush_move = fl && !pend && (cnt != '0) && (cnt != PACK_C) && out_free;
    flush_drop = fl && !pend && (cnt == '0);
    // Lanes already captured plus the one in flight must leave room.
    rinc       = !rrst && !rempty && !fl &&
                 (({1'b0, cnt} + {{CW{1'b0}}, pend}) < PACK_W);
    busy       = (cnt != '0) || pend || fl;
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      acc       <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
      fl        <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      pend <= rinc;

      // A capture and a move never coincide: a move needs cnt == PACK (so no
      // read can be in flight) or a flush with pend already clear.
      if (pend) begin
        for (int unsigned i = 0; i < PACK; i++) begin
          if (cnt == CW'(i)) begin
            acc[i*WIDTH +: WIDTH] <= rdata;
          end
        end
        cnt <= cnt + CW'(1);
      end

      if (full_move || flush_move) begin
        out_data  <= acc;
        out_cnt   <= full_move ? PACK_C : cnt;
        out_valid <= 1'b1;
        cnt       <= '0;
        acc       <= '0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (flush_move || flush_drop) begin
        fl <= 1'b0;
      end else if (flush) begin
        fl <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
module tb_fifo_rd_packer;

  localparam int WIDTH = 8;
  localparam int PACK  = 4;
  localparam int CW    = $clog2(PACK + 1);

  logic                  rclk = 1'b0;
  logic                  rrst;
  logic                  rempty;
  logic                  rinc;
  logic [WIDTH-1:0]      rdata;
  logic                  flush;
  logic [WIDTH*PACK-1:0] out_data;
  logic [CW-1:0]         out_cnt;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;

  fifo_rd_packer #(.WIDTH(WIDTH), .PACK(PACK)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rempty    (rempty),
    .rinc      (rinc),
    .rdata     (rdata),
    .flush     (flush),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic [WIDTH*PACK-1:0] data;
    logic [CW-1:0]         cnt;
  } word_t;

  logic [WIDTH-1:0] fifo_q[$];  // FIFO contents seen by the DUT
  logic [WIDTH-1:0] cur_q[$];   // popped entries not yet assigned to a word
  word_t            exp_q[$];   // words the consumer must see, in order

  int n_checks = 0;
  int n_err    = 0;

  logic                  s_rinc, s_valid, s_busy;
  logic [WIDTH*PACK-1:0] s_data;
  logic [CW-1:0]         s_cnt;
  logic                  prev_hold = 1'b0;
  logic [WIDTH*PACK-1:0] prev_data;
  logic [CW-1:0]         prev_cnt;
  logic [WIDTH-1:0]      rd_next;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic word_t make_word();
    word_t w;
    w.data = '0;
    w.cnt  = CW'(cur_q.size());
    foreach (cur_q[i]) w.data[i*WIDTH +: WIDTH] = cur_q[i];
    return w;
  endfunction

  task automatic push(input logic [WIDTH-1:0] d);
    fifo_q.push_back(d);
    rempty = 1'b0;
  endtask

  // Per-cycle comparison against the model, then model update.
  task automatic check_cycle();
    if (rrst) begin
      chk("rst_rinc",  64'(s_rinc),  64'd0);
      chk("rst_valid", 64'(s_valid), 64'd0);
      chk("rst_cnt",   64'(s_cnt),   64'd0);
      chk("rst_data",  64'(s_data),  64'd0);
      chk("rst_busy",  64'(s_busy),  64'd0);
      cur_q.delete();
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      chk("rinc_when_empty", 64'(s_rinc && rempty), 64'd0);
      if (prev_hold) begin
        chk("hold_valid", 64'(s_valid), 64'd1);
        chk("hold_data",  64'(s_data),  64'(prev_data));
        chk("hold_cnt",   64'(s_cnt),   64'(prev_cnt));
      end
      if (s_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL word_unexpected: got data %h cnt %0d, required no word", s_data, s_cnt);
        end else begin
          chk("word_data", 64'(s_data), 64'(exp_q[0].data));
          chk("word_cnt",  64'(s_cnt),  64'(exp_q[0].cnt));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_hold = s_valid && !out_ready;
      prev_data = s_data;
      prev_cnt  = s_cnt;
      if (s_rinc && fifo_q.size() != 0) begin
        rd_next = fifo_q.pop_front();
        cur_q.push_back(rd_next);
        if (cur_q.size() == PACK) begin
          exp_q.push_back(make_word());
          cur_q.delete();
        end
      end
      if (flush && cur_q.size() != 0) begin
        exp_q.push_back(make_word());
        cur_q.delete();
      end
    end
  endtask

  // Called 1 time unit after a rising edge; samples just before the next one.
  task automatic tick();
    #8;
    s_rinc  = rinc;
    s_valid = out_valid;
    s_busy  = busy;
    s_data  = out_data;
    s_cnt   = out_cnt;
    check_cycle();
    @(posedge rclk);
    #1;
    rdata  = rd_next;
    rempty = (fifo_q.size() == 0);
    flush  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      tick();
      done = (fifo_q.size() == 0) && (exp_q.size() == 0) && (cur_q.size() == 0) && !s_busy && !s_valid;
    end
    chk(name, 64'(done), 64'd1);
  endtask

  initial begin
    logic found;
    rrst      = 1'b1;
    rempty    = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    rdata     = '0;
    rd_next   = '0;
    @(posedge rclk);
    #1;

    // T1: reset held with a non-empty FIFO (literal checks in check_cycle)
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    out_ready = 1'b1;
    repeat (4) tick();
    rrst = 1'b0;

    // T2: fill, timing from the first rinc cycle
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t2_rinc", 64'(s_rinc), 64'(c < 4));
      if (c == 5) chk("t2_valid_c5", 64'(s_valid), 64'd0);
      if (c == 6) begin
        chk("t2_valid_c6", 64'(s_valid), 64'd1);
        chk("t2_data", 64'(s_data), 64'h44332211);
        chk("t2_cnt",  64'(s_cnt),  64'd4);
      end
      if (c == 7) chk("t2_valid_c7", 64'(s_valid), 64'd0);
    end
    wait_idle("t2_idle");

    // T3: backpressure
    out_ready = 1'b0;
    for (int d = 1; d <= 8; d++) push(WIDTH'(d));
    repeat (16) tick();
    for (int d = 9; d <= 12; d++) push(WIDTH'(d));
    tick();
    chk("t3_rinc_held", 64'(s_rinc),  64'd0);
    chk("t3_valid",     64'(s_valid), 64'd1);
    chk("t3_data",      64'(s_data),  64'h04030201);
    chk("t3_busy",      64'(s_busy),  64'd1);
    out_ready = 1'b1;
    tick();
    tick();
    chk("t3_valid2", 64'(s_valid), 64'd1);
    chk("t3_data2",  64'(s_data),  64'h08070605);
    wait_idle("t3_idle");

    // T4: flush a partial word
    push(8'hA1); push(8'hA2); push(8'hA3);
    repeat (8) tick();
    flush = 1'b1;
    tick();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      found = s_valid;
    end
    chk("t4_found", 64'(found), 64'd1);
    chk("t4_data",  64'(s_data), 64'h00A3A2A1);
    chk("t4_cnt",   64'(s_cnt),  64'd3);
    tick();
    chk("t4_busy", 64'(s_busy), 64'd0);
    wait_idle("t4_idle");

    // T5a: flush while empty and idle
    flush = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t5a_valid", 64'(s_valid), 64'd0);
    end
    // T5b: flush in the cycle after the last rinc
    push(8'hB1); push(8'hB2);
    tick();
    tick();
    flush = 1'b1;
    tick();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      found = s_valid;
    end
    chk("t5b_found", 64'(found), 64'd1);
    chk("t5b_data",  64'(s_data), 64'h0000B2B1);
    chk("t5b_cnt",   64'(s_cnt),  64'd2);
    wait_idle("t5_idle");

    // T6: reset after two lanes captured, third read in flight
    push(8'hC1); push(8'hC2); push(8'hC3);
    repeat (3) tick();
    rrst = 1'b1;
    tick();
    tick();
    rrst = 1'b0;
    tick();
    chk("t6_busy",  64'(s_busy),  64'd0);
    chk("t6_valid", 64'(s_valid), 64'd0);
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    found = 1'b0;
    for (int k = 0; k < 15 && !found; k++) begin
      tick();
      found = s_valid;
    end
    chk("t6_found", 64'(found), 64'd1);
    chk("t6_data",  64'(s_data), 64'hD4D3D2D1);
    chk("t6_cnt",   64'(s_cnt),  64'd4);
    wait_idle("t6_idle");

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 45) push(WIDTH'($urandom));
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 4);
      rrst      = ($urandom_range(0, 999) < 3);
      if (rrst) flush = 1'b0;
      tick();
    end
    rrst      = 1'b0;
    out_ready = 1'b1;
    found     = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (fifo_q.size() == 0 && cur_q.size() != 0) flush = 1'b1;
      tick();
      found = (fifo_q.size() == 0) && (exp_q.size() == 0) && (cur_q.size() == 0) && !s_busy && !s_valid;
    end
    chk("drain_idle", 64'(found), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
